// File: rtl/activation_output_writer_pkg.sv
// Shared widths and state encoding for the activation output writer slice.
package activation_output_writer_pkg;

  localparam int DEF_DWIDTH       = 8;
  localparam int DEF_MAT_MUL_SIZE = 4;
  localparam int DEF_MASK_WIDTH   = 4;
  localparam int DEF_AWIDTH       = 10;
  localparam int DEF_FIFO_DEPTH   = 4;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_ONE = 16'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/activation_output_writer_row_fifo.sv
// Synchronous row FIFO; one extra pointer bit separates full from empty.
module row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/activation_output_writer.sv
// Buffers activation rows and writes them to the output BRAM with strided
// addressing; dropped rows still consume their address slot in order.
module activation_output_writer
  import activation_output_writer_pkg::*;
#(
  parameter int DWIDTH       = DEF_DWIDTH,
  parameter int MAT_MUL_SIZE = DEF_MAT_MUL_SIZE,
  parameter int MASK_WIDTH   = DEF_MASK_WIDTH,
  parameter int AWIDTH       = DEF_AWIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [AWIDTH-1:0]              address_stride,
  input  logic [15:0]                    num_rows,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  input  logic                           bram_grant,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
  output logic [MASK_WIDTH-1:0]          bram_we,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int RW = MAT_MUL_SIZE * DWIDTH;
  localparam int EW = CNT_W + RW + MASK_WIDTH;

  state_t r_state;
  state_t w_state_nxt;

  logic [AWIDTH-1:0] r_stride;
  logic [AWIDTH-1:0] r_cur_addr;
  logic [CNT_W-1:0]  r_num_rows;
  logic [CNT_W-1:0]  r_accept_cnt;
  logic [CNT_W-1:0]  r_write_cnt;
  logic [CNT_W-1:0]  r_drop_pend;
  logic [CNT_W-1:0]  r_head_skipped;
  logic              r_overflow;
  logic [AWIDTH-1:0]     r_bram_addr;
  logic [RW-1:0]         r_bram_wdata;
  logic [MASK_WIDTH-1:0] r_bram_we;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_slot;
  logic                  w_head_skip;
  logic                  w_tail_skip;
  logic                  w_pop;
  logic                  w_skip;
  logic                  w_arm;
  logic [CNT_W-1:0]      w_tail_dec;
  logic [CNT_W-1:0]      w_pend_left;
  logic [EW-1:0]         w_fifo_din;
  logic [EW-1:0]         w_fifo_dout;
  logic [CNT_W-1:0]      w_head_skip_cnt;
  logic [RW-1:0]         w_head_data;
  logic [MASK_WIDTH-1:0] w_head_mask;

  // Each entry carries the number of dropped rows that precede it, so the
  // write side can burn those address slots before writing the entry.
  assign {w_head_skip_cnt, w_head_data, w_head_mask} = w_fifo_dout;

  assign w_arm       = (r_state == IDLE) && start;
  assign w_accept    = (r_state == ARMED) && in_data_available &&
                       (r_accept_cnt < r_num_rows);
  assign w_slot      = ((r_state == ARMED) || (r_state == DRAIN)) && bram_grant &&
                       (!w_fifo_empty || (r_drop_pend != '0));
  assign w_head_skip = !w_fifo_empty && (w_head_skip_cnt > r_head_skipped);
  assign w_tail_skip = w_fifo_empty && (r_drop_pend != '0);
  assign w_pop       = w_slot && !w_fifo_empty && !w_head_skip;
  assign w_skip      = w_slot && (w_head_skip || w_tail_skip);
  assign w_push      = w_accept && (!w_fifo_full || w_pop);
  assign w_drop      = w_accept && !w_push;
  assign w_tail_dec  = (w_skip && w_tail_skip) ? CNT_ONE : '0;
  assign w_pend_left = r_drop_pend - w_tail_dec;
  assign w_fifo_din  = {w_pend_left, in_data, validity_mask};

  row_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_fifo_din),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_num_rows     <= '0;
      r_accept_cnt   <= '0;
      r_write_cnt    <= '0;
      r_drop_pend    <= '0;
      r_head_skipped <= '0;
      r_overflow     <= 1'b0;
      r_bram_addr    <= '0;
      r_bram_wdata   <= '0;
      r_bram_we      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arm) begin
        r_num_rows     <= num_rows;
        r_accept_cnt   <= '0;
        r_write_cnt    <= '0;
        r_drop_pend    <= '0;
        r_head_skipped <= '0;
        r_overflow     <= 1'b0;
      end else begin
        if (w_accept) r_accept_cnt <= r_accept_cnt + CNT_ONE;
        if (w_drop)   r_overflow   <= 1'b1;
        if (w_push)      r_drop_pend <= '0;
        else if (w_drop) r_drop_pend <= w_pend_left + CNT_ONE;
        else             r_drop_pend <= w_pend_left;
        if (w_pop)                     r_head_skipped <= '0;
        else if (w_skip && w_head_skip) r_head_skipped <= r_head_skipped + CNT_ONE;
        if (w_pop || w_skip)           r_write_cnt    <= r_write_cnt + CNT_ONE;
      end
      if (w_pop) begin
        r_bram_addr  <= r_cur_addr;
        r_bram_wdata <= w_head_data;
        r_bram_we    <= w_head_mask;
      end else begin
        r_bram_we <= '0;
        if (w_skip) r_bram_addr <= r_cur_addr;
      end
    end
  end

  // Address datapath: no reset, reloaded on every start.
  always_ff @(posedge clk) begin
    if (w_arm) begin
      r_stride   <= address_stride;
      r_cur_addr <= base_addr;
    end else if (w_pop || w_skip) begin
      r_cur_addr <= r_cur_addr + r_stride;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE:  if (start) w_state_nxt = (num_rows == '0) ? DONE : ARMED;
      ARMED: begin
        busy = 1'b1;
        if (r_accept_cnt == r_num_rows) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_write_cnt == r_num_rows) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bram_addr  = r_bram_addr;
  assign bram_wdata = r_bram_wdata;
  assign bram_we    = r_bram_we;
  assign overflow   = r_overflow;

endmodule
